data_bus_target: RTL and testbench

Bus responder (slave) for the Tiny DSP data bus. It answers the strobe/read/write/write-hold sequences issued by the data bus master.
- Decodes a window of the address space.
- Serves reads from a small local register array and commits writes to it.
- Checks master protocol timing and reports violations.
- Sits on the pad side: its write-data input connects to the master's pad_data_out, and its read-data output drives the master's pad_data_in.

---
 rtl/data_bus_target_pkg.sv | 16 +
 rtl/data_bus_target_regfile.sv | 31 +++
 rtl/data_bus_target.sv | 144 ++++++++++++++
 tb/tb_data_bus_target.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_target_pkg.sv
// Shared definitions for the Tiny DSP data bus target: transfer state encoding and default geometry.
package data_bus_target_pkg;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_SEL   = 2'd1,
        T_WHOLD = 2'd2,
        T_DONE  = 2'd3
    } state_t;

    localparam int unsigned DBT_DATA_W     = 16;
    localparam int unsigned DBT_ADDR_W     = 8;
    localparam int unsigned DBT_DEPTH_LOG2 = 4;
    localparam logic [7:0]  DBT_BASE_ADDR  = 8'h80;

endpackage

// File: rtl/data_bus_target_regfile.sv
// Local word array for the data bus target: async clear, synchronous write, combinational read.
module data_bus_target_regfile #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_bus_target.sv
// Tiny DSP data bus responder: window decode, local register array, master protocol checking.
// Optional write protection input wr_lock is enabled by defining DATA_BUS_TARGET_WRPROT_EN.
module data_bus_target
    import data_bus_target_pkg::*;
#(
    parameter int unsigned       DATA_W     = DBT_DATA_W,
    parameter int unsigned       ADDR_W     = DBT_ADDR_W,
    parameter int unsigned       DEPTH_LOG2 = DBT_DEPTH_LOG2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = DBT_BASE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              as,
    input  logic              read,
    input  logic              write,
    input  logic              write_h,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              sel,
    output logic              busy,
    output logic              err,
`ifdef DATA_BUS_TARGET_WRPROT_EN
    input  logic              wr_lock,
`endif
    input  logic              err_clr
);

    state_t                  state;
    logic [DEPTH_LOG2-1:0]   index;
    logic [DEPTH_LOG2-1:0]   rd_index;
    logic [DATA_W-1:0]       rdq;
    logic [DATA_W-1:0]       wcap;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    hit;
    logic                    lock;
    logic                    mem_we;
    logic                    err_set;

`ifdef DATA_BUS_TARGET_WRPROT_EN
    assign lock = wr_lock;
`else
    assign lock = 1'b0;
`endif

    assign hit      = (address[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]);
    // In T_IDLE the array is read at the incoming address so rdq is valid one cycle after as rises.
    assign rd_index = (state == T_IDLE) ? address[DEPTH_LOG2-1:0] : index;

    data_bus_target_regfile #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (index),
        .wdata (wdata),
        .raddr (rd_index),
        .rdata (mem_rdata)
    );

    always_comb begin
        mem_we  = 1'b0;
        err_set = 1'b0;
        case (state)
            T_SEL: begin
                if (as) begin
                    if (read && write) begin
                        err_set = 1'b1;
                    end else if (write_h && !write) begin
                        err_set = 1'b1;
                    end else if (write && !read) begin
                        if (sel && lock) err_set = 1'b1;
                        else             mem_we  = sel;
                    end
                end
            end
            T_WHOLD: begin
                if (!as)                              err_set = 1'b1;
                else if (write_h && (wdata != wcap))  err_set = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= T_IDLE;
            index <= '0;
            rdq   <= '0;
            wcap  <= '0;
            sel   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= err_set | (err & ~err_clr);
            case (state)
                T_IDLE: begin
                    if (as) begin
                        index <= address[DEPTH_LOG2-1:0];
                        sel   <= hit;
                        rdq   <= hit ? mem_rdata : '0;
                        state <= T_SEL;
                        busy  <= 1'b1;
                    end
                end
                T_SEL: begin
                    rdq <= sel ? mem_rdata : '0;
                    if (!as) begin
                        state <= T_IDLE;
                        sel   <= 1'b0;
                        busy  <= 1'b0;
                    end else if (read || (write_h && !write)) begin
                        state <= T_DONE;
                    end else if (write) begin
                        wcap  <= wdata;
                        state <= T_WHOLD;
                    end
                end
                T_WHOLD: begin
                    if (!as) begin
                        state <= T_IDLE;
                        sel   <= 1'b0;
                        busy  <= 1'b0;
                    end else if (!write_h) begin
                        state <= T_DONE;
                    end
                end
                T_DONE: begin
                    if (!as) begin
                        state <= T_IDLE;
                        sel   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= T_IDLE;
            endcase
        end
    end

    assign rdata = (sel && read && (state == T_SEL)) ? rdq : '0;

endmodule

// File: tb/tb_data_bus_target.sv
// Self-checking bench for data_bus_target against a word-array reference model.
module tb_data_bus_target;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        as = 1'b0, read = 1'b0, write = 1'b0, write_h = 1'b0, err_clr = 1'b0;
    logic [7:0]  address = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        sel, busy, err;
`ifdef DATA_BUS_TARGET_WRPROT_EN
    logic        wr_lock = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] model [16];

    always #5 clk = ~clk;

    data_bus_target #(
        .DATA_W     (16),
        .ADDR_W     (8),
        .DEPTH_LOG2 (4),
        .BASE_ADDR  (8'h80)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .as      (as),
        .read    (read),
        .write   (write),
        .write_h (write_h),
        .address (address),
        .wdata   (wdata),
        .rdata   (rdata),
        .sel     (sel),
        .busy    (busy),
        .err     (err),
`ifdef DATA_BUS_TARGET_WRPROT_EN
        .wr_lock (wr_lock),
`endif
        .err_clr (err_clr)
    );

    function automatic bit in_window(input logic [7:0] a);
        return (int'(a) / 16) == (int'(8'h80) / 16);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [15:0] rd, output logic s);
        as = 1'b1; address = a;
        tick;
        read = 1'b1;
        #1;
        rd = rdata;
        s  = sel;
        tick;
        read = 1'b0; as = 1'b0;
        tick;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit commit);
        as = 1'b1; address = a;
        tick;
        write = 1'b1; wdata = d;
        tick;
        write = 1'b0; write_h = 1'b1;
        tick;
        tick;
        write_h = 1'b0;
        tick;
        as = 1'b0;
        tick;
        if (commit && in_window(a)) model[int'(a) % 16] = d;
    endtask

    task automatic clear_err(input string name);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL %s err=%b expected 0", name, err);
        end
    endtask

    task automatic test_reset;
        logic [15:0] rd;
        logic s;
        @(posedge clk);
        #1;
        checks++;
        if ({sel, err, busy, rdata} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs sel=%b err=%b busy=%b rdata=%h expected all 0", sel, err, busy, rdata);
        end
        #3 reset = 1'b0;
        model_clear();
        tick;
        for (int i = 0; i < 16; i += 5) begin
            do_read(8'h80 + 8'(i), rd, s);
            checks++;
            if (rd !== model[i]) begin
                failures++;
                $display("FAIL reset_mem word=%0d rdata=%h expected %h", i, rd, model[i]);
            end
        end
    endtask

    task automatic test_read_hit;
        logic [15:0] rd;
        logic s;
        do_write(8'h83, 16'hA5A5, 1'b1);
        do_read(8'h83, rd, s);
        checks++;
        if (rd !== 16'hA5A5 || s !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL read_hit rdata=%h sel=%b err=%b expected a5a5 1 0", rd, s, err);
        end
    endtask

    task automatic test_write_hit;
        logic [15:0] rd;
        logic s;
        do_write(8'h85, 16'h1234, 1'b1);
        do_read(8'h85, rd, s);
        checks++;
        if (rd !== 16'h1234 || err !== 1'b0) begin
            failures++;
            $display("FAIL write_hit rdata=%h err=%b expected 1234 0", rd, err);
        end
    endtask

    task automatic test_miss;
        logic [15:0] rd;
        logic s;
        do_write(8'h10, 16'hFFFF, 1'b1);
        do_read(8'h10, rd, s);
        checks++;
        if (rd !== 16'h0000 || s !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL miss rdata=%h sel=%b err=%b expected 0 0 0", rd, s, err);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(8'h80 + 8'(i), rd, s);
            checks++;
            if (rd !== model[i]) begin
                failures++;
                $display("FAIL miss_untouched word=%0d rdata=%h expected %h", i, rd, model[i]);
            end
        end
    endtask

    task automatic test_protocol_errors;
        logic [15:0] rd;
        logic s;
        // read and write together, with a clear on the same edge
        as = 1'b1; address = 8'h84;
        tick;
        read = 1'b1; write = 1'b1; err_clr = 1'b1;
        tick;
        read = 1'b0; write = 1'b0; err_clr = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_rw_set_wins err=%b expected 1", err);
        end
        as = 1'b0;
        tick;
        clear_err("err_clr_rw");

        // write data changes during hold
        as = 1'b1; address = 8'h86;
        tick;
        write = 1'b1; wdata = 16'h0001;
        tick;
        write = 1'b0; write_h = 1'b1;
        tick;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable err=%b expected 0", err);
        end
        wdata = 16'h0002;
        tick;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL hold_change err=%b expected 1", err);
        end
        write_h = 1'b0;
        tick;
        as = 1'b0;
        tick;
        model[6] = 16'h0001;
        clear_err("err_clr_hold");

        // strobe dropped while write_h is high
        as = 1'b1; address = 8'h87;
        tick;
        write = 1'b1; wdata = 16'h0007;
        tick;
        write = 1'b0; write_h = 1'b1;
        tick;
        as = 1'b0;
        tick;
        write_h = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL as_drop_hold err=%b busy=%b expected 1 0", err, busy);
        end
        model[7] = 16'h0007;
        clear_err("err_clr_asdrop");

        for (int i = 4; i < 8; i++) begin
            do_read(8'h80 + 8'(i), rd, s);
            checks++;
            if (rd !== model[i]) begin
                failures++;
                $display("FAIL proto_mem word=%0d rdata=%h expected %h", i, rd, model[i]);
            end
        end
    endtask

    task automatic test_grant_wait;
        logic [15:0] rd;
        logic s;
        as = 1'b1; address = 8'h89; wdata = 16'h5555;
        repeat (10) tick;
        checks++;
        if (busy !== 1'b1 || sel !== 1'b1) begin
            failures++;
            $display("FAIL grant_wait_busy busy=%b sel=%b expected 1 1", busy, sel);
        end
        as = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || sel !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL grant_wait_idle busy=%b sel=%b err=%b expected 0 0 0", busy, sel, err);
        end
        do_read(8'h89, rd, s);
        checks++;
        if (rd !== model[9]) begin
            failures++;
            $display("FAIL grant_wait_mem rdata=%h expected %h", rd, model[9]);
        end
    endtask

    task automatic test_random;
        logic [15:0] rd, d;
        logic [7:0]  a;
        logic        s;
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) != 0) ? (8'h80 | 8'($urandom_range(0, 15))) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                do_write(a, d, 1'b1);
            end else begin
                do_read(a, rd, s);
                checks++;
                if (rd !== (in_window(a) ? model[int'(a) % 16] : 16'h0000) || s !== in_window(a)) begin
                    failures++;
                    $display("FAIL random_read addr=%h rdata=%h sel=%b expected %h %b", a, rd, s,
                             in_window(a) ? model[int'(a) % 16] : 16'h0000, in_window(a));
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL random_err err=%b expected 0", err);
        end
    endtask

`ifdef DATA_BUS_TARGET_WRPROT_EN
    task automatic test_wrprot;
        logic [15:0] rd;
        logic s;
        wr_lock = 1'b1;
        do_write(8'h82, 16'hBEEF, 1'b0);
        wr_lock = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL wrprot_err err=%b expected 1", err);
        end
        do_read(8'h82, rd, s);
        checks++;
        if (rd !== model[2]) begin
            failures++;
            $display("FAIL wrprot_mem rdata=%h expected %h", rd, model[2]);
        end
        clear_err("err_clr_wrprot");
    endtask
`endif

    task automatic test_reset_mid;
        logic [15:0] rd;
        logic s;
        as = 1'b1; address = 8'h8A;
        tick;
        read = 1'b1; write = 1'b1;
        tick;
        read = 1'b0; write = 1'b0; as = 1'b0;
        tick;
        as = 1'b1;
        tick;
        write = 1'b1; wdata = 16'hCAFE;
        tick;
        write = 1'b0; write_h = 1'b1;
        tick;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sel, err, busy, rdata} !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid sel=%b err=%b busy=%b rdata=%h expected all 0", sel, err, busy, rdata);
        end
        as = 1'b0; write_h = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        tick;
        for (int i = 0; i < 16; i += 3) begin
            do_read(8'h80 + 8'(i), rd, s);
            checks++;
            if (rd !== model[i]) begin
                failures++;
                $display("FAIL reset_mid_mem word=%0d rdata=%h expected %h", i, rd, model[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_miss();
        test_protocol_errors();
        test_grant_wait();
        test_random();
`ifdef DATA_BUS_TARGET_WRPROT_EN
        test_wrprot();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
